// File: rtl/interleave_chain_checker_pkg.sv
// Shared types for the interleaved chain checker: FSM state encoding and error codes.
package interleave_chain_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRECHECK = 3'd1,
        ST_TOGGLE   = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;
    localparam logic [1:0] ERR_GLITCH  = 2'd3;

endpackage

// File: rtl/interleave_chain_checker_tap_sync.sv
// Per-bit flop chain bringing raw chain taps into the checker clock domain.
// DEPTH of zero means the taps are already synchronous and pass straight through.
module interleave_chain_checker_tap_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q[0] <= d;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/interleave_chain_checker.sv
// Drives stim into a shoelaced chain and checks every toggle ripples through the
// stage taps in order, with the right polarity, inside a cycle budget.
module interleave_chain_checker
    import interleave_chain_checker_pkg::*;
#(
    parameter int                  N_STAGES  = 5,
    parameter logic [N_STAGES-1:0] INV_MASK  = 5'b10101,
    parameter int                  TIMEOUT   = 16,
    parameter int                  N_TOGGLES = 8,
    parameter int                  SYNC      = 2,
    parameter int                  LAT_W     = 8,
    localparam int                 PW        = $clog2(N_STAGES) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_STAGES-1:0] taps,
    output logic                stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          err_code,
    output logic [PW-1:0]       err_stage,
    output logic [LAT_W-1:0]    toggle_cnt,
    output logic [LAT_W-1:0]    max_lat,
    output state_t              state_dbg
);

    state_t              state, state_next;
    logic [N_STAGES-1:0] s;
    logic [N_STAGES-1:0] prev_s;
    logic [N_STAGES-1:0] exp_v;
    logic [N_STAGES-1:0] rising;
    logic [PW-1:0]       ptr;
    logic [LAT_W-1:0]    lat;

    logic [PW-1:0] p;
    logic          run;
    logic          glitch_hit, order_hit, mism_hit;
    logic [PW-1:0] glitch_idx, order_idx, mism_idx;
    logic          all_set, timeout_hit, last_toggle;

    interleave_chain_checker_tap_sync #(
        .WIDTH(N_STAGES),
        .DEPTH(SYNC)
    ) u_tap_sync (
        .clk  (clk),
        .reset(reset),
        .d    (taps),
        .q    (s)
    );

    assign exp_v  = {N_STAGES{stim}} ^ INV_MASK;
    // A stage "arrives" when it changed this sample and now shows its expected level.
    assign rising = (s ^ prev_s) & ~(s ^ exp_v);

    // Settle pointer scan plus lowest-index error search.
    always_comb begin
        p          = ptr;
        run        = 1'b1;
        glitch_hit = 1'b0;
        glitch_idx = '0;
        order_hit  = 1'b0;
        order_idx  = '0;
        mism_hit   = 1'b0;
        mism_idx   = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (run && (PW'(i) >= ptr)) begin
                if (s[i] == exp_v[i]) begin
                    p = PW'(i + 1);
                end else begin
                    run = 1'b0;
                end
            end
        end
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if ((PW'(i) < ptr) && (s[i] != exp_v[i])) begin
                glitch_hit = 1'b1;
                glitch_idx = PW'(i);
            end
            if ((PW'(i) > p) && rising[i]) begin
                order_hit = 1'b1;
                order_idx = PW'(i);
            end
            if (s[i] != exp_v[i]) begin
                mism_hit = 1'b1;
                mism_idx = PW'(i);
            end
        end
    end

    assign all_set     = (p == PW'(N_STAGES));
    assign timeout_hit = (lat == LAT_W'(TIMEOUT)) && !all_set;
    assign last_toggle = ((toggle_cnt + LAT_W'(1)) == LAT_W'(N_TOGGLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_PRECHECK;
                end
            end
            ST_PRECHECK: state_next = mism_hit ? ST_ERR : ST_TOGGLE;
            ST_TOGGLE:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (glitch_hit || order_hit || timeout_hit) begin
                    state_next = ST_ERR;
                end else if (all_set) begin
                    state_next = last_toggle ? ST_DONE : ST_TOGGLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stim       <= 1'b0;
            prev_s     <= '0;
            ptr        <= '0;
            lat        <= '0;
            err_code   <= ERR_NONE;
            err_stage  <= '0;
            toggle_cnt <= '0;
            max_lat    <= '0;
        end else begin
            prev_s <= s;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        err_code   <= ERR_NONE;
                        err_stage  <= '0;
                        toggle_cnt <= '0;
                        max_lat    <= '0;
                    end
                end
                ST_PRECHECK: begin
                    if (mism_hit) begin
                        err_code  <= ERR_GLITCH;
                        err_stage <= mism_idx;
                    end
                end
                ST_TOGGLE: begin
                    stim <= ~stim;
                    ptr  <= '0;
                    lat  <= '0;
                end
                ST_WAIT: begin
                    ptr <= p;
                    if (lat != {LAT_W{1'b1}}) begin
                        lat <= lat + LAT_W'(1);
                    end
                    // Priority: glitch, then order, then timeout.
                    if (glitch_hit) begin
                        err_code  <= ERR_GLITCH;
                        err_stage <= glitch_idx;
                    end else if (order_hit) begin
                        err_code  <= ERR_ORDER;
                        err_stage <= order_idx;
                    end else if (timeout_hit) begin
                        err_code  <= ERR_TIMEOUT;
                        err_stage <= p;
                    end else if (all_set) begin
                        if (toggle_cnt != {LAT_W{1'b1}}) begin
                            toggle_cnt <= toggle_cnt + LAT_W'(1);
                        end
                        if (lat > max_lat) begin
                            max_lat <= lat;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == ST_PRECHECK) || (state == ST_TOGGLE) || (state == ST_WAIT);
    assign done      = (state == ST_DONE) || (state == ST_ERR);
    assign pass      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_interleave_chain_checker.sv
// Bench: a chain model with planned per-stage delays and faults, an arrival-time
// reference model, and a scoreboard checked whenever a run reports done.
module tb_interleave_chain_checker;
  import interleave_chain_checker_pkg::*;

  localparam int N = 5;
  localparam logic [N-1:0] MASK = 5'b10101;
  localparam int TIMEOUT = 16;
  localparam int NT = 8;
  localparam int SYNC = 2;
  localparam int LW = 8;
  localparam int PW = $clog2(N) + 1;
  localparam int W = 2 + PW + LW + LW + 2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [N-1:0] taps;
  logic stim, busy, done, pass;
  logic [1:0] err_code;
  logic [PW-1:0] err_stage;
  logic [LW-1:0] toggle_cnt, max_lat;
  state_t state_dbg;

  interleave_chain_checker #(
    .N_STAGES(N), .INV_MASK(MASK), .TIMEOUT(TIMEOUT),
    .N_TOGGLES(NT), .SYNC(SYNC), .LAT_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .taps(taps), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .err_stage(err_stage), .toggle_cnt(toggle_cnt), .max_lat(max_lat),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- run plan ----------------
  int dly[NT][N];
  int stuck_tog, stuck_stage;
  int gl_tog, gl_stage, gl_time;
  logic [N-1:0] idle_err_mask;
  bit plan_active;
  int exp_stim;
  int tog_lat[NT];

  // Chain model: stage i of toggle k flips to its new level d cycles after stim changes.
  logic last_stim;
  bit in_toggle;
  int cur_tog, tog_idx, cnt;
  always @(negedge clk) begin
    if (!plan_active) begin
      taps = {N{stim}} ^ MASK ^ idle_err_mask;
      last_stim = stim;
      in_toggle = 0;
      tog_idx = 0;
    end else begin
      if (stim != last_stim) begin
        last_stim = stim;
        cur_tog = tog_idx;
        tog_idx++;
        cnt = 0;
        in_toggle = 1;
      end
      if (in_toggle && cur_tog < NT) begin
        for (int i = 0; i < N; i++)
          if (cnt == dly[cur_tog][i] && !(cur_tog == stuck_tog && i == stuck_stage))
            taps[i] = stim ^ MASK[i];
        if (cur_tog == gl_tog && cnt == gl_time)
          taps[gl_stage] = ~(stim ^ MASK[gl_stage]);
        cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  // True when synchronized stage i shows its new level at latency t of toggle k.
  function automatic bit stage_ok(input int k, input int i, input int t);
    if (t < 0) return 0;
    if (k == stuck_tog && i == stuck_stage) return 0;
    if (t < dly[k][i] + SYNC) return 0;
    if (k == gl_tog && i == gl_stage && t >= gl_time + SYNC) return 0;
    return 1;
  endfunction

  task automatic model_toggle(input int k, output int code, output int stg, output int lat_o);
    int ptr, p, g, o;
    code = 0; stg = 0; lat_o = 0; ptr = 0;
    for (int t = 0; t <= TIMEOUT; t++) begin
      g = -1; o = -1; p = ptr;
      for (int j = ptr - 1; j >= 0; j--) if (!stage_ok(k, j, t)) g = j;
      while (p < N && stage_ok(k, p, t)) p++;
      for (int q = N - 1; q > p; q--) if (stage_ok(k, q, t) && !stage_ok(k, q, t - 1)) o = q;
      if (g >= 0) begin code = 3; stg = g; return; end
      if (o >= 0) begin code = 2; stg = o; return; end
      if (p == N) begin lat_o = t; return; end
      if (t == TIMEOUT) begin code = 1; stg = p; return; end
      ptr = p;
    end
  endtask

  task automatic model_run(input bit use_plan, output logic [W-1:0] e, output int flips,
                           output int cycles);
    int code, stg, tcnt, ml, l;
    code = 0; stg = 0; tcnt = 0; ml = 0; flips = 0; cycles = 1;
    if (!use_plan) begin
      for (int i = N - 1; i >= 0; i--) if (idle_err_mask[i]) begin code = 3; stg = i; end
    end else begin
      for (int k = 0; k < NT; k++) begin
        flips++;
        model_toggle(k, code, stg, l);
        if (code != 0) break;
        tog_lat[k] = l;
        cycles += l + 2;
        tcnt++;
        if (l > ml) ml = l;
      end
    end
    e = {code[1:0], stg[PW-1:0], tcnt[LW-1:0], ml[LW-1:0], (code == 0), exp_stim[0] ^ flips[0]};
  endtask

  task automatic ideal_plan();
    stuck_tog = -1; gl_tog = -1; idle_err_mask = '0;
    for (int k = 0; k < NT; k++)
      for (int i = 0; i < N; i++) dly[k][i] = i + 1;
  endtask

  task automatic gen_plan(input int mode);
    int k;
    stuck_tog = -1; gl_tog = -1; idle_err_mask = '0;
    for (int t = 0; t < NT; t++) begin
      dly[t][0] = $urandom_range(0, 2);
      for (int i = 1; i < N; i++) dly[t][i] = dly[t][i-1] + $urandom_range(0, 2);
    end
    k = $urandom_range(0, NT - 1);
    case (mode)
      1: for (int i = 0; i < N; i++) dly[k][i] = $urandom_range(0, 8);
      2: begin stuck_tog = k; stuck_stage = $urandom_range(0, N - 1); end
      3: begin
        dly[k][N-1] = dly[k][N-2] + 1;
        gl_tog = k;
        gl_stage = $urandom_range(0, N - 2);
        gl_time = $urandom_range(dly[k][gl_stage] + 1, dly[k][N-1]);
      end
      4: idle_err_mask = N'($urandom_range(1, (1 << N) - 1));
      5: for (int i = 0; i < N; i++) dly[k][i] = $urandom_range(0, 16);
      default: ;
    endcase
  endtask

  // poke: 0 none, 1 start while busy, 2 start in the cycle of the final settle
  task automatic run_plan(input bit use_plan, input int poke);
    logic [W-1:0] e;
    int flips, cycles, n;
    plan_active = 0;
    repeat (SYNC + 3) @(negedge clk);
    model_run(use_plan, e, flips, cycles);
    exp_q.push_back(e);
    plan_active = use_plan;
    start = 1;
    @(negedge clk);
    start = 0;
    if (poke == 1) begin
      repeat (4) @(negedge clk);
      check("busy_mid_run", busy, 1);
      start = 1;
      @(negedge clk);
      start = 0;
    end else if (poke == 2) begin
      repeat (cycles - 1) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      check("done_after_settle_start", done, 1);
      check("state_after_settle_start", int'(state_dbg), int'(ST_DONE));
    end
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("run_done_timeout", 0, 1);
    @(negedge clk);
    plan_active = 0;
    idle_err_mask = '0;
    exp_stim = exp_stim ^ flips;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stim"}, stim, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_err_stage"}, err_stage, 0);
    check({tag, "_toggle_cnt"}, toggle_cnt, 0);
    check({tag, "_max_lat"}, max_lat, 0);
    check({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  logic done_q = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("err_code", err_code, int'(e[W-1 -: 2]));
        check("err_stage", err_stage, int'(e[W-3 -: PW]));
        check("toggle_cnt", toggle_cnt, int'(e[2*LW+1 -: LW]));
        check("max_lat", max_lat, int'(e[LW+1 -: LW]));
        check("pass", pass, int'(e[1]));
        check("stim", stim, int'(e[0]));
        check("busy_at_done", busy, 0);
      end
    end
    done_q = done;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1; start = 0; plan_active = 0; idle_err_mask = '0; exp_stim = 0;
    stuck_tog = -1; gl_tog = -1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 0;

    ideal_plan();                                  // every stage one cycle behind the last
    run_plan(1, 0);
    ideal_plan();                                  // stages 1 and 2 settle together
    for (int k = 0; k < NT; k++) begin dly[k][1] = 2; dly[k][2] = 2; end
    run_plan(1, 0);
    ideal_plan();                                  // stage 3 overtakes stage 2 on second toggle
    dly[1][2] = 4; dly[1][3] = 3; dly[1][4] = 5;
    run_plan(1, 0);
    ideal_plan();                                  // stage 4 stuck on toggle 1
    stuck_tog = 1; stuck_stage = 4;
    run_plan(1, 0);
    ideal_plan();                                  // stage 0 reverts after settling
    gl_tog = 0; gl_stage = 0; gl_time = 3;
    run_plan(1, 0);
    ideal_plan();                                  // mis-set tap before start
    idle_err_mask = 5'b00100;
    run_plan(0, 0);

    // Reset in the middle of a run.
    ideal_plan();
    plan_active = 0;
    repeat (SYNC + 3) @(negedge clk);
    plan_active = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    check("busy_before_reset", busy, 1);
    @(posedge clk);
    #2 reset = 1;
    plan_active = 0;
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    reset = 0;
    exp_stim = 0;

    ideal_plan();
    run_plan(1, 1);
    gen_plan(0);
    run_plan(1, 2);

    for (int r = 0; r < 24; r++) begin
      int mode;
      mode = $urandom_range(0, 5);
      gen_plan(mode);
      run_plan(mode != 4, (mode == 0) ? 1 : 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
